// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multicycle MIPS datapath. Sequences each
//   instruction through fetch, decode, execute, memory and write-back,
//   stalling in memory states until mem_ready. Outputs are a Moore decode
//   of the state, qualified by mem_ready in FETCH/MEMWRITE and by opcode
//   in DECODE/BRANCH.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   opcode[5:0]             instruction register bits [31:26]
//   mem_ready               memory completes current access this cycle
//   pc_write, branch_eq/ne  PC load enables (unconditional / on zero / on !zero)
//   iord                    memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write     memory strobes
//   ir_write                instruction register load
//   mem_to_reg, reg_dst     write-back and destination selects
//   reg_write               register file write enable
//   alu_src_a, alu_src_b    ALU operand selects
//   alu_op                  to alu_control (00 add, 01 sub, 10 funct)
//   pc_source               PC mux select (00 ALU, 01 ALUOut, 10 jump)
//   instr_done              last cycle of an instruction
//   illegal_op              one-cycle pulse after decode of unsupported opcode
//   state[3:0]              current state (debug)
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t r_state;
  state_t w_next;
  logic   r_illegal_op;
  logic   w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: w_legal = 1'b1;
      default:                                               w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_illegal_op <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_illegal_op <= (r_state == S_DECODE) && !w_legal;
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      w_next = S_EXECUTE;
          OP_LW, OP_SW:  w_next = S_MEMADR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:       w_next = S_ADDIEX;
          OP_J:          w_next = S_JUMP;
          default: begin
            w_next     = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 2'b01;
        instr_done = 1'b1;
        branch_eq  = (opcode == OP_BEQ);
        branch_ne  = (opcode == OP_BNE);
        w_next     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      // Unreachable codes recover to FETCH with every output low.
      default: w_next = S_FETCH;
    endcase
  end

  assign illegal_op = r_illegal_op;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch_eq, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Packed view of all control outputs except state.
  logic [18:0] act;
  assign act = {pc_write, branch_eq, branch_ne, iord, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source, instr_done, illegal_op};

  localparam logic [18:0] PCW   = 19'd1 << 18;
  localparam logic [18:0] BEQ   = 19'd1 << 17;
  localparam logic [18:0] BNE   = 19'd1 << 16;
  localparam logic [18:0] IORD  = 19'd1 << 15;
  localparam logic [18:0] MRD   = 19'd1 << 14;
  localparam logic [18:0] MWR   = 19'd1 << 13;
  localparam logic [18:0] IRW   = 19'd1 << 12;
  localparam logic [18:0] M2R   = 19'd1 << 11;
  localparam logic [18:0] RDST  = 19'd1 << 10;
  localparam logic [18:0] RW    = 19'd1 << 9;
  localparam logic [18:0] SRCA  = 19'd1 << 8;
  localparam logic [18:0] SB4   = 19'd1 << 6;
  localparam logic [18:0] SBIMM = 19'd2 << 6;
  localparam logic [18:0] SBSH  = 19'd3 << 6;
  localparam logic [18:0] AOSUB = 19'd1 << 4;
  localparam logic [18:0] AOF   = 19'd2 << 4;
  localparam logic [18:0] PCS1  = 19'd1 << 2;
  localparam logic [18:0] PCS2  = 19'd2 << 2;
  localparam logic [18:0] DONE  = 19'd1 << 1;
  localparam logic [18:0] ILL   = 19'd1;

  localparam logic [18:0] E_FR    = MRD | SB4 | IRW | PCW;
  localparam logic [18:0] E_FS    = MRD | SB4;
  localparam logic [18:0] E_DEC   = SBSH;
  localparam logic [18:0] E_MADR  = SRCA | SBIMM;
  localparam logic [18:0] E_MRD   = MRD | IORD;
  localparam logic [18:0] E_MWB   = RW | M2R | DONE;
  localparam logic [18:0] E_MWS   = MWR | IORD;
  localparam logic [18:0] E_MWR   = MWR | IORD | DONE;
  localparam logic [18:0] E_EXE   = SRCA | AOF;
  localparam logic [18:0] E_AWB   = RW | RDST | DONE;
  localparam logic [18:0] E_BEQ   = SRCA | AOSUB | PCS1 | DONE | BEQ;
  localparam logic [18:0] E_BNE   = SRCA | AOSUB | PCS1 | DONE | BNE;
  localparam logic [18:0] E_AIEX  = SRCA | SBIMM;
  localparam logic [18:0] E_AIWB  = RW | DONE;
  localparam logic [18:0] E_JMP   = PCW | PCS2 | DONE;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [18:0] out;
  } vec_t;

  vec_t vecs[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string nm, input logic [18:0] a, input logic [18:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, a, e, $time);
    end
  endtask

  // Apply inputs on the falling edge, compare shortly after, well before the
  // next rising edge.
  task automatic step(input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic [18:0] out, input string nm);
    @(negedge clk);
    opcode    = op;
    mem_ready = mr;
    #1;
    chk({nm, "_state"}, {15'd0, state}, {15'd0, st});
    chk({nm, "_out"}, act, out);
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic mr,
                              input logic [3:0] st, input logic [18:0] out);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.out = out;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0;

    // R-type
    vecs.push_back(mk(6'h00, 1'b1, 4'd1,  E_FR));
    vecs.push_back(mk(6'h00, 1'b1, 4'd2,  E_DEC));
    vecs.push_back(mk(6'h00, 1'b1, 4'd7,  E_EXE));
    vecs.push_back(mk(6'h00, 1'b1, 4'd8,  E_AWB));
    // lw with 2 FETCH stalls and 3 MEMREAD stalls: 10 cycles
    vecs.push_back(mk(6'h23, 1'b0, 4'd1,  E_FS));
    vecs.push_back(mk(6'h23, 1'b0, 4'd1,  E_FS));
    vecs.push_back(mk(6'h23, 1'b1, 4'd1,  E_FR));
    vecs.push_back(mk(6'h23, 1'b1, 4'd2,  E_DEC));
    vecs.push_back(mk(6'h23, 1'b1, 4'd3,  E_MADR));
    vecs.push_back(mk(6'h23, 1'b0, 4'd4,  E_MRD));
    vecs.push_back(mk(6'h23, 1'b0, 4'd4,  E_MRD));
    vecs.push_back(mk(6'h23, 1'b0, 4'd4,  E_MRD));
    vecs.push_back(mk(6'h23, 1'b1, 4'd4,  E_MRD));
    vecs.push_back(mk(6'h23, 1'b1, 4'd5,  E_MWB));
    // beq, bne
    vecs.push_back(mk(6'h04, 1'b1, 4'd1,  E_FR));
    vecs.push_back(mk(6'h04, 1'b1, 4'd2,  E_DEC));
    vecs.push_back(mk(6'h04, 1'b1, 4'd9,  E_BEQ));
    vecs.push_back(mk(6'h05, 1'b1, 4'd1,  E_FR));
    vecs.push_back(mk(6'h05, 1'b1, 4'd2,  E_DEC));
    vecs.push_back(mk(6'h05, 1'b1, 4'd9,  E_BNE));
    // sw with one write stall
    vecs.push_back(mk(6'h2B, 1'b1, 4'd1,  E_FR));
    vecs.push_back(mk(6'h2B, 1'b1, 4'd2,  E_DEC));
    vecs.push_back(mk(6'h2B, 1'b1, 4'd3,  E_MADR));
    vecs.push_back(mk(6'h2B, 1'b0, 4'd6,  E_MWS));
    vecs.push_back(mk(6'h2B, 1'b1, 4'd6,  E_MWR));
    // j
    vecs.push_back(mk(6'h02, 1'b1, 4'd1,  E_FR));
    vecs.push_back(mk(6'h02, 1'b1, 4'd2,  E_DEC));
    vecs.push_back(mk(6'h02, 1'b1, 4'd12, E_JMP));
    // addi
    vecs.push_back(mk(6'h08, 1'b1, 4'd1,  E_FR));
    vecs.push_back(mk(6'h08, 1'b1, 4'd2,  E_DEC));
    vecs.push_back(mk(6'h08, 1'b1, 4'd10, E_AIEX));
    vecs.push_back(mk(6'h08, 1'b1, 4'd11, E_AIWB));
    // illegal opcode: 2 cycles, pulse in the following FETCH only
    vecs.push_back(mk(6'h3F, 1'b1, 4'd1,  E_FR));
    vecs.push_back(mk(6'h3F, 1'b1, 4'd2,  E_DEC | DONE));
    vecs.push_back(mk(6'h3F, 1'b1, 4'd1,  E_FR | ILL));
    vecs.push_back(mk(6'h23, 1'b1, 4'd2,  E_DEC));

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_state", {15'd0, state}, 19'd0);
      chk("rst_out", act, 19'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_state", {15'd0, state}, 19'd0);
    chk("idle_out", act, 19'd0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].out, $sformatf("vec%0d", i));

    // Finish the lw into a MEMREAD wait, then reset asynchronously.
    step(6'h23, 1'b1, 4'd3, E_MADR, "lwr_madr");
    step(6'h23, 1'b0, 4'd4, E_MRD,  "lwr_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", {15'd0, state}, 19'd0);
    chk("async_rst_out", act, 19'd0);
    @(negedge clk);
    #1;
    chk("held_rst_out", act, 19'd0);
    rst_n = 1'b1;
    step(6'h23, 1'b1, 4'd1, E_FR, "post_rst_fetch");
    step(6'h00, 1'b1, 4'd2, E_DEC, "post_rst_dec");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
